// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters (IDLE -> DRIVE -> RESP).
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins and no grant pointer is kept.
module alu_arbiter #(
    parameter int unsigned SETTLE = 32'd1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rq0_valid,
    output logic        rq0_ready,
    input  logic [5:0]  rq0_op,
    input  logic [31:0] rq0_a,
    input  logic [31:0] rq0_b,
    input  logic [15:0] rq0_value,
    input  logic        rq0_highlow,
    input  logic        rq1_valid,
    output logic        rq1_ready,
    input  logic [5:0]  rq1_op,
    input  logic [31:0] rq1_a,
    input  logic [31:0] rq1_b,
    input  logic [15:0] rq1_value,
    input  logic        rq1_highlow,
    output logic [5:0]  alu_instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [15:0] alu_value,
    output logic        alu_highlow,
    input  logic [31:0] alu_c,
    input  logic        alu_f3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_flag,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 32'd1);
    localparam logic [5:0] ALU_IDLE_OP = 6'h3F;

    function automatic logic is_cmp_op(input logic [5:0] op);
        return (op >= 6'd8) && (op <= 6'd13);
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return op < 6'd16;
    endfunction

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        id_q;
    logic        busy_q;
    logic [5:0]  alu_instr_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [15:0] alu_value_q;
    logic        alu_highlow_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [31:0] rsp_data_q;
    logic        rsp_flag_q;
    logic        rsp_err_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic        last_q;
`endif

    logic        grant0_s;
    logic        grant1_s;
    logic        accept_s;
    logic        sel_id_s;
    logic [5:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [15:0] sel_value_s;
    logic        sel_highlow_s;

    // Arbitration winner among the valid requesters
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (rq0_valid) begin
            grant0_s = 1'b1;
        end else if (rq1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
        end
`else
        // last_q holds the id granted most recently; the other side wins a tie
        if (rq0_valid && rq1_valid) begin
            grant0_s = last_q;
            grant1_s = ~last_q;
        end else if (rq0_valid) begin
            grant0_s = 1'b1;
        end else if (rq1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
        end
`endif
    end

    assign rq0_ready = (state_q == IDLE) && grant0_s;
    assign rq1_ready = (state_q == IDLE) && grant1_s;
    assign accept_s  = rq0_ready || rq1_ready;

    // Operand mux for the winning requester
    always_comb begin
        if (grant1_s) begin
            sel_id_s      = 1'b1;
            sel_op_s      = rq1_op;
            sel_a_s       = rq1_a;
            sel_b_s       = rq1_b;
            sel_value_s   = rq1_value;
            sel_highlow_s = rq1_highlow;
        end else begin
            sel_id_s      = 1'b0;
            sel_op_s      = rq0_op;
            sel_a_s       = rq0_a;
            sel_b_s       = rq0_b;
            sel_value_s   = rq0_value;
            sel_highlow_s = rq0_highlow;
        end
    end

    // Control FSM; the alu_* registers double as the latched request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            id_q          <= 1'b0;
            busy_q        <= 1'b0;
            alu_instr_q   <= ALU_IDLE_OP;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_value_q   <= 16'd0;
            alu_highlow_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_flag_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q        <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        id_q   <= sel_id_s;
                        busy_q <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_q <= sel_id_s;
`endif
                        if (is_legal_op(sel_op_s)) begin
                            state_q       <= DRIVE;
                            cnt_q         <= SETTLE_LAST;
                            alu_instr_q   <= sel_op_s;
                            alu_a_q       <= sel_a_s;
                            alu_b_q       <= sel_b_s;
                            alu_value_q   <= sel_value_s;
                            alu_highlow_q <= sel_highlow_s;
                        end else begin
                            // Illegal opcode never reaches the ALU
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= sel_id_s;
                            rsp_data_q  <= 32'd0;
                            rsp_flag_q  <= 1'b0;
                            rsp_err_q   <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt_q == 3'd0) begin
                        state_q       <= RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_id_q      <= id_q;
                        rsp_data_q    <= alu_c;
                        rsp_flag_q    <= is_cmp_op(alu_instr_q) ? alu_f3 : 1'b0;
                        rsp_err_q     <= 1'b0;
                        alu_instr_q   <= ALU_IDLE_OP;
                        alu_a_q       <= 32'd0;
                        alu_b_q       <= 32'd0;
                        alu_value_q   <= 16'd0;
                        alu_highlow_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    rsp_valid_q   <= 1'b0;
                    alu_instr_q   <= ALU_IDLE_OP;
                    alu_a_q       <= 32'd0;
                    alu_b_q       <= 32'd0;
                    alu_value_q   <= 16'd0;
                    alu_highlow_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_instr   = alu_instr_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_value   = alu_value_q;
    assign alu_highlow = alu_highlow_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_flag    = rsp_flag_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: random two-requester traffic against a transaction-level model.
module tb_alu_arbiter;

    localparam int S = 3;

    logic        clock;
    logic        reset_n;
    logic        rq0_valid, rq1_valid, rq0_ready, rq1_ready;
    logic [5:0]  rq0_op, rq1_op;
    logic [31:0] rq0_a, rq0_b, rq1_a, rq1_b;
    logic [15:0] rq0_value, rq1_value;
    logic        rq0_highlow, rq1_highlow;
    logic [5:0]  alu_instr;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [15:0] alu_value;
    logic        alu_highlow, alu_f3;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_flag, rsp_err, busy;
    logic [31:0] rsp_data;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] v;
        logic        hl;
    } req_t;

    typedef struct {
        req_t        r;
        logic        id;
        logic        legal;
        logic [31:0] data;
        logic        flag;
        logic        err;
        int          acc_cyc;
    } exp_t;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   model_idle = 1'b1;
    bit   m_last = 1'b1;
    bit   mon_en = 1'b0;

    alu_arbiter #(.SETTLE(S)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_op(rq0_op), .rq0_a(rq0_a),
        .rq0_b(rq0_b), .rq0_value(rq0_value), .rq0_highlow(rq0_highlow),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_op(rq1_op), .rq1_a(rq1_a),
        .rq1_b(rq1_b), .rq1_value(rq1_value), .rq1_highlow(rq1_highlow),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_value(alu_value),
        .alu_highlow(alu_highlow), .alu_c(alu_c), .alu_f3(alu_f3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural ALU: returns {compare flag, result}
    function automatic logic [32:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] v,
                                            input logic hl);
        logic [31:0] c;
        logic        f;
        case (op)
            6'd0:    c = a + b;
            6'd1:    c = a - b;
            6'd2:    c = a & b;
            6'd3:    c = a | b;
            6'd4:    c = a ^ b;
            6'd5:    c = hl ? {v, 16'h0000} : {16'h0000, v};
            6'd6:    c = a << b[4:0];
            6'd7:    c = a >> b[4:0];
            default: c = a ^ {26'd0, op};
        endcase
        case (op)
            6'd8:    f = (a == b);
            6'd9:    f = (a != b);
            6'd10:   f = ($signed(a) < $signed(b));
            6'd11:   f = ($signed(a) >= $signed(b));
            6'd12:   f = (a < b);
            6'd13:   f = (a >= b);
            default: f = a[0] ^ b[0];
        endcase
        return {f, c};
    endfunction

    always_comb {alu_f3, alu_c} = alu_ref(alu_instr, alu_a, alu_b, alu_value, alu_highlow);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        int   k;
        k      = $urandom_range(0, 9);
        r.op   = (k == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
        r.a    = $urandom;
        r.b    = (k == 1) ? r.a : $urandom;
        r.v    = 16'($urandom);
        r.hl   = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic req_t mk_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.v = 16'h0000; r.hl = 1'b0;
        return r;
    endfunction

    function automatic exp_t mk_exp(input req_t r, input logic id, input int c);
        exp_t        e;
        logic [32:0] res;
        res       = alu_ref(r.op, r.a, r.b, r.v, r.hl);
        e.r       = r;
        e.id      = id;
        e.legal   = (r.op < 6'd16);
        e.data    = e.legal ? res[31:0] : 32'd0;
        e.flag    = (e.legal && r.op >= 6'd8 && r.op <= 6'd13) ? res[32] : 1'b0;
        e.err     = ~e.legal;
        e.acc_cyc = c;
        return e;
    endfunction

    task automatic check_reset_outs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_alu_instr"}, 32'(alu_instr), 32'h3F);
        chk({tag, "_alu_ops"}, alu_a | alu_b | {16'd0, alu_value} | {31'd0, alu_highlow}, 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_bits"}, {29'd0, rsp_id, rsp_flag, rsp_err}, 32'd0);
        chk({tag, "_ready"}, {30'd0, rq1_ready, rq0_ready}, 32'd0);
    endtask

    // Drives requests from q0/q1 and predicts each grant until all traffic drains
    task automatic run_traffic(input bit always_valid, input int max_cycles);
        int   guard;
        int   c0;
        logic w;
        bit   take;
        req_t r0, r1, rr;
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0 || !model_idle) && guard < max_cycles) begin
            @(negedge clock);
            guard++;
            c0 = cyc;
            if (q0.size() > 0) begin
                r0 = q0[0];
                rq0_valid = always_valid || ($urandom_range(0, 3) != 0);
            end else begin
                r0 = '0;
                rq0_valid = 1'b0;
            end
            if (q1.size() > 0) begin
                r1 = q1[0];
                rq1_valid = always_valid || ($urandom_range(0, 3) != 0);
            end else begin
                r1 = '0;
                rq1_valid = 1'b0;
            end
            {rq0_op, rq0_a, rq0_b, rq0_value, rq0_highlow} = r0;
            {rq1_op, rq1_a, rq1_b, rq1_value, rq1_highlow} = r1;
            #1;
            take = 1'b0;
            w    = 1'b0;
            if (model_idle && (rq0_valid || rq1_valid)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                w = rq0_valid ? 1'b0 : 1'b1;
`else
                w = (rq0_valid && rq1_valid) ? ~m_last : rq1_valid;
`endif
                chk("grant0", 32'(rq0_ready), 32'(w == 1'b0));
                chk("grant1", 32'(rq1_ready), 32'(w == 1'b1));
                take = 1'b1;
            end else begin
                chk("ready_off", {30'd0, rq1_ready, rq0_ready}, 32'd0);
            end
            @(posedge clock);
            if (take) begin
                rr = w ? q1.pop_front() : q0.pop_front();
                sb.push_back(mk_exp(rr, w, c0));
                model_idle = 1'b0;
                m_last     = w;
            end
        end
        n_cmp++;
        if (guard >= max_cycles) begin
            n_err++;
            $display("FAIL traffic_timeout: got %0d cycles without draining, limit %0d", guard, max_cycles);
        end
        @(negedge clock);
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
    endtask

    // Monitor: drives rsp_ready back-pressure, pops the scoreboard on each response handshake
    initial begin : monitor
        int   low_run;
        int   d;
        bit   exp_v;
        bit   in_drive;
        exp_t e;
        low_run   = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (low_run > 0) begin
                rsp_ready = 1'b0;
                low_run--;
            end else if ($urandom_range(0, 5) == 0) begin
                rsp_ready = 1'b0;
                low_run = $urandom_range(0, 4);
            end else begin
                rsp_ready = 1'b1;
            end
            #2;
            if (mon_en) begin
                chk("busy", 32'(busy), 32'(!model_idle));
                if (model_idle || sb.size() == 0) begin
                    chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                    chk("alu_idle_instr", 32'(alu_instr), 32'h3F);
                    chk("alu_idle_ops", alu_a | alu_b | {16'd0, alu_value} | {31'd0, alu_highlow}, 32'd0);
                end else begin
                    e        = sb[0];
                    d        = cyc - e.acc_cyc;
                    in_drive = e.legal && d >= 1 && d <= S;
                    exp_v    = e.legal ? (d > S) : (d >= 1);
                    chk("rsp_valid_timing", 32'(rsp_valid), 32'(exp_v));
                    if (in_drive) begin
                        chk("alu_instr", 32'(alu_instr), 32'(e.r.op));
                        chk("alu_a", alu_a, e.r.a);
                        chk("alu_b", alu_b, e.r.b);
                        chk("alu_value_hl", {15'd0, alu_value, alu_highlow}, {15'd0, e.r.v, e.r.hl});
                    end else begin
                        chk("alu_rest_instr", 32'(alu_instr), 32'h3F);
                    end
                    if (rsp_valid) begin
                        chk("rsp_id", 32'(rsp_id), 32'(e.id));
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_flag", 32'(rsp_flag), 32'(e.flag));
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            @(posedge clock);
                            model_idle = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        int c0;
        reset_n   = 1'b0;
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        {rq0_op, rq0_a, rq0_b, rq0_value, rq0_highlow} = '0;
        {rq1_op, rq1_a, rq1_b, rq1_value, rq1_highlow} = '0;
        repeat (3) @(negedge clock);
        check_reset_outs("reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Directed: add, equal-compare flag, illegal opcode
        q0.push_back(mk_req(6'd0, 32'd5, 32'd7));
        q1.push_back(mk_req(6'd8, 32'd3, 32'd3));
        q0.push_back(mk_req(6'd20, 32'hDEAD_BEEF, 32'h1234_5678));
        run_traffic(1'b1, 400);

        // Both requesters continuously valid, three ops each
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk_req(6'd1, 32'(100 + i), 32'd1));
            q1.push_back(mk_req(6'd2, 32'hFFFF_0000, 32'(i)));
        end
        run_traffic(1'b1, 400);

        // Random traffic with valid toggling and response back-pressure
        for (int i = 0; i < 40; i++) begin
            q0.push_back(rand_req());
            q1.push_back(rand_req());
        end
        run_traffic(1'b0, 6000);

        // Reset during the second DRIVE cycle of a requester-0 op
        @(negedge clock);
        c0 = cyc;
        {rq0_op, rq0_a, rq0_b, rq0_value, rq0_highlow} = mk_req(6'd0, 32'd1, 32'd2);
        rq0_valid = 1'b1;
        #1;
        chk("rst_test_grant", 32'(rq0_ready), 32'd1);
        @(posedge clock);
        sb.push_back(mk_exp(mk_req(6'd0, 32'd1, 32'd2), 1'b0, c0));
        model_idle = 1'b0;
        m_last     = 1'b0;
        @(negedge clock);
        rq0_valid = 1'b0;
        @(negedge clock);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outs("mid_reset");
        repeat (3) begin
            @(negedge clock);
            chk("mid_reset_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
        end
        reset_n = 1'b1;
        sb.delete();
        model_idle = 1'b1;
        m_last     = 1'b1;
        mon_en     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk_req(6'd4, 32'(7 * i), 32'h0F0F_0F0F));
            q1.push_back(mk_req(6'd3, 32'(i), 32'h8000_0000));
        end
        run_traffic(1'b1, 400);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: SETTLE, 1, cycles the ALU inputs are held stable before the result is captured; legal range 1..7.
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports rqN_valid  input  1  request N valid, for N = 0, 1.
REQ-005 SHALL have ports rqN_ready  output  1  request N accepted this cycle, for N = 0, 1.
REQ-006 SHALL have ports rqN_op  input  6  opcode for request N, for N = 0, 1.
REQ-007 SHALL have ports rqN_a and rqN_b  input  32 each  operands for request N, for N = 0, 1.
REQ-008 SHALL have ports rqN_value  input  16 and rqN_highlow  input  1  load immediate and half select, for N = 0, 1.
REQ-009 SHALL have ports alu_instr  output  6; alu_a and alu_b  output  32 each; alu_value  output  16; alu_highlow  output  1; together these drive the shared ALU.
REQ-010 SHALL have ports alu_c  input  32  ALU result, and alu_f3  input  1  ALU compare flag.
REQ-011 SHALL have ports rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (which requester is answered); rsp_data  output  32; rsp_flag  output  1; rsp_err  output  1.
REQ-012 SHALL have port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, DRIVE and RESP.
REQ-014 In IDLE, SHALL combinationally assert rqN_ready only for the arbitration winner among the valid requesters; an accept is valid & ready at a rising edge.
REQ-015 Arbitration SHALL be round-robin with a last-grant pointer: if both requesters are valid, the one not granted last wins; the pointer updates only on an accept.
REQ-016 On accept, SHALL latch op, a, b, value, highlow and the requester id, then enter DRIVE.
REQ-017 In DRIVE, SHALL hold the alu_* outputs at the latched values for exactly SETTLE cycles.
REQ-018 At the last DRIVE edge, SHALL capture rsp_data = alu_c, and rsp_flag = alu_f3 for opcodes 8..13 (rsp_flag = 0 otherwise), then enter RESP.
REQ-019 rsp_valid SHALL rise exactly SETTLE edges after the accept edge.
REQ-020 SHALL drive the alu_* outputs to alu_instr = 6'h3F and all other alu_* outputs to 0 when not in DRIVE.
REQ-021 An opcode of 16 or more SHALL be accepted, SHALL skip DRIVE, and SHALL enter RESP on the next edge with rsp_data = 0, rsp_flag = 0 and rsp_err = 1; rsp_err SHALL be 0 for legal opcodes.
REQ-022 In RESP, SHALL hold rsp_* stable until rsp_valid & rsp_ready, then return to IDLE; no rqN_ready SHALL be asserted in that same cycle.
REQ-023 rqN_ready SHALL be 0 in DRIVE and RESP; a requester dropping valid without a handshake SHALL have no effect.
REQ-024 The minimum issue interval SHALL be SETTLE + 2 cycles.

Reset
REQ-025 While reset_n is low, SHALL hold: state IDLE; rsp_valid, rsp_flag, rsp_err, rsp_id = 0; rsp_data = 0; busy = 0; alu_* outputs as in REQ-020; last-grant pointer = 1, so requester 0 wins first.
REQ-026 Reset asserted during DRIVE or RESP SHALL discard the operation with no response issued.

Configuration
REQ-027 With ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win when valid and the pointer SHALL not exist; without the macro, arbitration is round-robin per REQ-015.

Verification
REQ-028 SETTLE = 1, rq0 op 0, a = 5, b = 7, alu_c mirrors the ALU -> alu_instr = 0 for 1 cycle; rsp_valid next cycle; rsp_data = 12, rsp_id = 0, rsp_err = 0.
REQ-029 Both valid continuously, three ops each -> grant order 0, 1, 0, 1, 0, 1; with ALU_ARB_FIXED_PRIO_EN -> all requester-0 ops first.
REQ-030 rq1 op 8, a = b = 3, alu_f3 = 1 -> rsp_flag = 1, rsp_id = 1.
REQ-031 rq0 op 20 -> no alu_instr change from 6'h3F; rsp one cycle later with rsp_err = 1, rsp_data = 0.
REQ-032 rsp_ready held low 5 cycles -> rsp_* stable, both rqN_ready = 0, busy = 1; rsp_ready high -> IDLE, with the next accept no earlier than the following cycle.
REQ-033 SETTLE = 3, reset_n pulsed low in the 2nd DRIVE cycle -> no rsp_valid; all outputs at reset values; the next grant goes to requester 0.
